fft_frame_capture: RTL and testbench
====================================

# fft_frame_capture

Capture-and-readout controller that sits between the debounced control keys, the MOD_FFT core and the board output pins. It issues the FFT `start` pulse, captures one complete output frame (`xk_re`/`xk_im`, index-addressed) into an internal buffer, and streams the frame out in ascending bin order over a valid/ready port. Compared with the fixed-width test harness it replaces, it is parametrised in data width and point count, and adds a continuous re-arm mode, a frame counter, and sticky error flags.

## Interface
- `OPD_DW`, 16, FFT output component width
- `POINTS_LOG`, 8, log2 of frame length; `POINTS = 2**POINTS_LOG`
- `FCNT_DW`, 16, frame counter width
- `clk`  in  1  single clock (the FFT clock)
- `rst`  in  1  reset, synchronous, active-high
- `start_req`  in  1  one-cycle request from debounced key
- `cont_mode`  in  1  1 = re-arm automatically after each readout
- `fft_start`  out  1  start pulse to FFT core
- `fft_soud`, `fft_opd`, `fft_eoud`  in  1 each  FFT output start / valid / end strobes
- `fft_idx`  in  POINTS_LOG  bin index of the current output
- `fft_xk_re`, `fft_xk_im`  in  OPD_DW each  signed output sample
- `rd_valid`  out  1;  `rd_ready`  in  1  readout handshake
- `rd_data`  out  2*OPD_DW  {re, im}, re in the upper half
- `rd_idx`  out  POINTS_LOG  bin of `rd_data`
- `rd_last`  out  1  high with bin POINTS-1
- `frame_cnt`  out  FCNT_DW  completed readouts, wraps
- `overrun`  out  1  sticky: FFT output seen outside a capture
- `short_frame`  out  1  sticky: `fft_eoud` with fewer than POINTS samples

## Operation
- States: IDLE, ARM, WAIT_OUT, CAPTURE, DRAIN.
- IDLE: `start_req`=1 -> ARM. ARM lasts exactly one cycle with `fft_start`=1 -> WAIT_OUT.
- WAIT_OUT: `fft_soud`=1 -> CAPTURE. The sample in the same cycle is written if `fft_opd`=1.
- WAIT_OUT/CAPTURE: each cycle with `fft_opd`=1 writes {re,im} to `buf[fft_idx]` and increments the sample count. If `fft_opd` and `fft_eoud` are both 1, that sample is written, then the state becomes DRAIN. If the count at that point is not POINTS, set `short_frame`; the frame is still drained.
- DRAIN: read the buffer from address 0 to POINTS-1. Drain completes on the `rd_valid & rd_ready & rd_last` handshake; at that handshake `frame_cnt`+1. Next state: ARM if `cont_mode`=1 (sampled in that cycle), else IDLE.
- `start_req` outside IDLE is ignored. `fft_opd` in IDLE, ARM or DRAIN sets `overrun`; that data is dropped and the buffer is unchanged.
- Handshake: once `rd_valid` is asserted, `rd_data`/`rd_idx`/`rd_last` stay stable until accepted. `rd_valid` never drops without acceptance.
- Flags clear only on `rst`.

## Timing
- Reset values: `fft_start`=0, `rd_valid`=0, `rd_data`=0, `rd_idx`=0, `rd_last`=0, `frame_cnt`=0, `overrun`=0, `short_frame`=0, state IDLE. Buffer contents are not reset.
- `rst` mid-operation aborts any state to IDLE on the next edge. A partially drained frame is discarded, and `frame_cnt` is not incremented.
- `fft_start` goes high the cycle after `start_req` is sampled in IDLE.
- Buffer read latency is 1 cycle (registered). The first `rd_valid` rises 2 cycles after the cycle the final `fft_eoud` is sampled.
- Throughput is 1 word/cycle while `rd_ready`=1, using a 2-entry output skid so that `rd_ready` deasserting loses no word. With `rd_ready` held at 1, the drain takes POINTS+2 cycles from `fft_eoud` to the last handshake.
- In continuous mode, `fft_start` is asserted the cycle after the last handshake.

## Structure
- Shared package: state encoding constants and the `{re,im}` packing width (2*OPD_DW). POINTS is derived from POINTS_LOG there.
- One sub-module, `fft_cap_buf`: simple dual-port RAM, depth POINTS, width 2*OPD_DW, one write port, registered read port, inferable as block RAM.
- FSM, counters, skid and flags live in the top module.

## Test plan
- POINTS_LOG=3, OPD_DW=16: `start_req` pulse -> `fft_start` high for exactly 1 cycle. Feed 8 samples in bit-reversed `fft_idx` with re=idx, im=-idx -> readout in bins 0..7 with `rd_data`={idx,-idx}, `rd_last` only on bin 7, `frame_cnt`=1.
- Toggle `rd_ready` randomly (50%) during drain -> all 8 words delivered once, in order, with stable data while stalled.
- `cont_mode`=1, single `start_req` -> three back-to-back frames captured and drained, `frame_cnt`=3, `fft_start` the cycle after each last handshake.
- `fft_opd` pulses while in IDLE -> `overrun`=1, buffer content from the previous frame unchanged on the next readout.
- `fft_eoud` after 5 samples -> `short_frame`=1, 8 words still drained, `frame_cnt` increments.
- Assert `rst` mid-drain after 3 words -> all outputs return to reset values next cycle, `frame_cnt`=0; a subsequent `start_req` works normally.

Source files
------------

// File: rtl/fft_frame_capture_pkg.sv
// Shared types and sizing helpers for the FFT frame capture controller.
package fft_frame_capture_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitOut,
        StCapture,
        StDrain
    } cap_state_e;

    // Width of one buffered word: {re, im}.
    function automatic int unsigned pack_width(input int unsigned opd_dw);
        return 2 * opd_dw;
    endfunction

    function automatic int unsigned points_of(input int unsigned points_log);
        return 32'd1 << points_log;
    endfunction

endpackage

// File: rtl/fft_cap_buf.sv
// Frame buffer: simple dual-port RAM, one write port, registered read port.
module fft_cap_buf
    import fft_frame_capture_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned Depth = points_of(AW);

    logic [DW-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_frame_capture.sv
// Issues FFT start, captures one index-addressed output frame and streams it out in bin order.
module fft_frame_capture
    import fft_frame_capture_pkg::*;
#(
    parameter int unsigned OPD_DW     = 16,
    parameter int unsigned POINTS_LOG = 8,
    parameter int unsigned FCNT_DW    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_req,
    input  logic                          cont_mode,
    output logic                          fft_start,
    input  logic                          fft_soud,
    input  logic                          fft_opd,
    input  logic                          fft_eoud,
    input  logic [POINTS_LOG-1:0]         fft_idx,
    input  logic [OPD_DW-1:0]             fft_xk_re,
    input  logic [OPD_DW-1:0]             fft_xk_im,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [pack_width(OPD_DW)-1:0] rd_data,
    output logic [POINTS_LOG-1:0]         rd_idx,
    output logic                          rd_last,
    output logic [FCNT_DW-1:0]            frame_cnt,
    output logic                          overrun,
    output logic                          short_frame
);

    localparam int unsigned Points = points_of(POINTS_LOG);
    localparam int unsigned PackW  = pack_width(OPD_DW);
    localparam int unsigned CntW   = POINTS_LOG + 1;
    localparam int unsigned EntW   = 1 + POINTS_LOG + PackW;

    cap_state_e state_q, state_d;

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [POINTS_LOG-1:0] raddr_q, raddr_d;
    logic                  issued_q, issued_d;
    logic                  infl_q, infl_d;
    logic [POINTS_LOG-1:0] infl_idx_q, infl_idx_d;
    logic                  byp_q, byp_d;
    logic [PackW-1:0]      byp_data_q, byp_data_d;
    logic [FCNT_DW-1:0]    frame_cnt_q, frame_cnt_d;
    logic                  overrun_q, overrun_d;
    logic                  short_q, short_d;

    logic [EntW-1:0] fifo_q [2];
    logic            fifo_wp_q, fifo_wp_d;
    logic            fifo_rp_q, fifo_rp_d;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;

    logic             capturing, wr_en, cap_end, rd_en, credit_ok;
    logic             fifo_push, fifo_pop, drain_done;
    logic [PackW-1:0] wr_data, ram_rdata;
    logic [EntW-1:0]  fifo_in;

    fft_cap_buf #(
        .AW(POINTS_LOG),
        .DW(PackW)
    ) u_buf (
        .clk  (clk),
        .we   (wr_en),
        .waddr(fft_idx),
        .wdata(wr_data),
        .re   (rd_en),
        .raddr(raddr_q),
        .rdata(ram_rdata)
    );

    assign rd_valid                           = (fifo_cnt_q != 2'd0);
    assign {rd_last, rd_idx, rd_data}         = fifo_q[fifo_rp_q];
    assign frame_cnt                          = frame_cnt_q;
    assign overrun                            = overrun_q;
    assign short_frame                        = short_q;

    always_comb begin
        wr_data    = {fft_xk_re, fft_xk_im};
        capturing  = (state_q == StWaitOut) || (state_q == StCapture);
        wr_en      = capturing && fft_opd;
        cap_end    = wr_en && fft_eoud;
        fifo_pop   = rd_valid && rd_ready;
        fifo_push  = infl_q;
        drain_done = (state_q == StDrain) && fifo_pop && rd_last;
        // Reads start in the final capture cycle so the first word is valid two cycles later.
        credit_ok  = (3'(fifo_cnt_q) + 3'(infl_q)) <= (3'd1 + 3'(fifo_pop));
        rd_en      = credit_ok && (cap_end || ((state_q == StDrain) && !issued_q));

        // The last captured sample can target the bin being read in the same cycle.
        byp_d      = rd_en && wr_en && (fft_idx == raddr_q);
        byp_data_d = wr_data;
        infl_d     = rd_en;
        infl_idx_d = rd_en ? raddr_q : infl_idx_q;
        fifo_in    = {&infl_idx_q, infl_idx_q, byp_q ? byp_data_q : ram_rdata};

        fifo_wp_d  = fifo_wp_q ^ fifo_push;
        fifo_rp_d  = fifo_rp_q ^ fifo_pop;
        fifo_cnt_d = fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);

        raddr_d  = raddr_q;
        issued_d = issued_q;
        if (state_q == StArm) begin
            raddr_d  = '0;
            issued_d = 1'b0;
        end else if (rd_en) begin
            raddr_d  = raddr_q + POINTS_LOG'(1);
            issued_d = &raddr_q;
        end

        cnt_d = cnt_q;
        if (state_q == StArm) begin
            cnt_d = '0;
        end else if (wr_en) begin
            cnt_d = cnt_q + CntW'(1);
        end

        short_d     = short_q || (cap_end && ((cnt_q + CntW'(1)) != CntW'(Points)));
        overrun_d   = overrun_q || (fft_opd && !capturing);
        frame_cnt_d = frame_cnt_q + FCNT_DW'(drain_done);
    end

    always_comb begin
        state_d   = state_q;
        fft_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_req) state_d = StArm;
            end
            StArm: begin
                fft_start = 1'b1;
                state_d   = StWaitOut;
            end
            StWaitOut: begin
                if (cap_end) state_d = StDrain;
                else if (fft_soud) state_d = StCapture;
            end
            StCapture: begin
                if (cap_end) state_d = StDrain;
            end
            StDrain: begin
                if (drain_done) state_d = cont_mode ? StArm : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            raddr_q     <= '0;
            issued_q    <= 1'b0;
            infl_q      <= 1'b0;
            infl_idx_q  <= '0;
            byp_q       <= 1'b0;
            byp_data_q  <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            short_q     <= 1'b0;
            fifo_wp_q   <= 1'b0;
            fifo_rp_q   <= 1'b0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            raddr_q     <= raddr_d;
            issued_q    <= issued_d;
            infl_q      <= infl_d;
            infl_idx_q  <= infl_idx_d;
            byp_q       <= byp_d;
            byp_data_q  <= byp_data_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            short_q     <= short_d;
            fifo_wp_q   <= fifo_wp_d;
            fifo_rp_q   <= fifo_rp_d;
            fifo_cnt_q  <= fifo_cnt_d;
            if (fifo_push) begin
                fifo_q[fifo_wp_q] <= fifo_in;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_capture.sv
// Self-checking bench for fft_frame_capture with an 8-point frame and a queue-based readout model.
module tb_fft_frame_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_req = 1'b0;
    logic        cont_mode = 1'b0;
    logic        fft_start;
    logic        fft_soud = 1'b0;
    logic        fft_opd = 1'b0;
    logic        fft_eoud = 1'b0;
    logic [2:0]  fft_idx = '0;
    logic [15:0] fft_xk_re = '0;
    logic [15:0] fft_xk_im = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [31:0] rd_data;
    logic [2:0]  rd_idx;
    logic        rd_last;
    logic [15:0] frame_cnt;
    logic        overrun;
    logic        short_frame;

    fft_frame_capture #(
        .OPD_DW    (16),
        .POINTS_LOG(3),
        .FCNT_DW   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_req  (start_req),
        .cont_mode  (cont_mode),
        .fft_start  (fft_start),
        .fft_soud   (fft_soud),
        .fft_opd    (fft_opd),
        .fft_eoud   (fft_eoud),
        .fft_idx    (fft_idx),
        .fft_xk_re  (fft_xk_re),
        .fft_xk_im  (fft_xk_im),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_idx     (rd_idx),
        .rd_last    (rd_last),
        .frame_cnt  (frame_cnt),
        .overrun    (overrun),
        .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_hs_cyc = -10;

    logic [31:0] model_buf [8];
    int          exp_idx [$];
    logic [31:0] exp_data [$];
    int          ord [5] = '{3, 6, 1, 5, 0};

    logic        prev_hold = 1'b0;
    logic [35:0] prev_word;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Readout compare: every accepted word against the expected queue, plus stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("stall_valid", rd_valid, 1'b1);
                check("stall_stable", {rd_last, rd_idx, rd_data}, prev_word);
            end
            if (rd_valid && rd_ready) begin
                if (exp_idx.size() == 0) begin
                    check("word_expected", exp_idx.size(), 1);
                end else begin
                    int          ei;
                    logic [31:0] ed;
                    ei = exp_idx.pop_front();
                    ed = exp_data.pop_front();
                    check("rd_idx", rd_idx, ei);
                    check("rd_data", rd_data, ed);
                    check("rd_last", rd_last, (ei == 7));
                end
                if (rd_last) last_hs_cyc = cyc;
            end
            prev_hold = rd_valid && !rd_ready;
            prev_word = {rd_last, rd_idx, rd_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bitrev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    task automatic pulse_start();
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
    endtask

    // Called in the ARM cycle; n==8 uses bit-reversed order, otherwise ord[].
    task automatic feed_frame(input int n, input bit idx_data);
        tick();
        for (int k = 0; k < n; k++) begin
            int          ix;
            logic [15:0] re, im;
            ix = (n == 8) ? bitrev3(k) : ord[k];
            if (idx_data) begin
                re = 16'(ix);
                im = -16'(ix);
            end else begin
                re = 16'($urandom);
                im = 16'($urandom);
            end
            fft_opd   = 1'b1;
            fft_soud  = (k == 0);
            fft_eoud  = (k == n - 1);
            fft_idx   = 3'(ix);
            fft_xk_re = re;
            fft_xk_im = im;
            model_buf[ix] = {re, im};
            tick();
        end
        fft_opd  = 1'b0;
        fft_soud = 1'b0;
        fft_eoud = 1'b0;
        for (int b = 0; b < 8; b++) begin
            exp_idx.push_back(b);
            exp_data.push_back(model_buf[b]);
        end
    endtask

    task automatic wait_frames(input int target, input string name);
        for (int i = 0; i < 300 && frame_cnt != 16'(target); i++) tick();
        check(name, frame_cnt, target);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 100 && !fft_start; i++) tick();
        check("cont_start_seen", fft_start, 1'b1);
        check("cont_start_cycle", cyc, last_hs_cyc + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int starts;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_fft_start", fft_start, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_idx", rd_idx, 3'd0);
        check("rst_rd_last", rd_last, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_short", short_frame, 1'b0);
        tick();

        // Frame 1: bit-reversed order, re=idx, im=-idx, ready held high.
        pulse_start();
        check("start_pulse_hi", fft_start, 1'b1);
        tick();
        check("start_pulse_lo", fft_start, 1'b0);
        for (int k = 0; k < 8; k++) begin
            fft_opd   = 1'b1;
            fft_soud  = (k == 0);
            fft_eoud  = (k == 7);
            fft_idx   = 3'(bitrev3(k));
            fft_xk_re = 16'(bitrev3(k));
            fft_xk_im = -16'(bitrev3(k));
            model_buf[bitrev3(k)] = {fft_xk_re, fft_xk_im};
            tick();
        end
        fft_opd  = 1'b0;
        fft_soud = 1'b0;
        fft_eoud = 1'b0;
        for (int b = 0; b < 8; b++) begin
            exp_idx.push_back(b);
            exp_data.push_back(model_buf[b]);
        end
        check("first_valid_lo", rd_valid, 1'b0);
        tick();
        check("first_valid_hi", rd_valid, 1'b1);
        check("first_idx", rd_idx, 3'd0);
        tick();
        check("second_word", rd_data, 32'h0001_FFFF);
        wait_frames(1, "frame_cnt_1");
        check("exp_drained_1", exp_idx.size(), 0);
        check("no_rearm", fft_start, 1'b0);

        // Frame 2: random data, random back-pressure.
        pulse_start();
        feed_frame(8, 1'b0);
        for (int i = 0; i < 300 && frame_cnt != 16'd2; i++) begin
            rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rd_ready = 1'b1;
        check("frame_cnt_2", frame_cnt, 16'd2);
        check("exp_drained_2", exp_idx.size(), 0);
        check("overrun_clean", overrun, 1'b0);

        // Stray output strobes in IDLE: flagged and dropped.
        for (int i = 0; i < 3; i++) begin
            fft_opd   = 1'b1;
            fft_idx   = 3'($urandom);
            fft_xk_re = 16'($urandom);
            fft_xk_im = 16'($urandom);
            tick();
        end
        fft_opd = 1'b0;
        tick();
        check("overrun_set", overrun, 1'b1);
        check("short_clean", short_frame, 1'b0);

        // Short frame of 5: the other 3 bins must still hold frame 2 data.
        pulse_start();
        feed_frame(5, 1'b0);
        tick();
        check("short_set", short_frame, 1'b1);
        wait_frames(3, "frame_cnt_3");
        check("exp_drained_3", exp_idx.size(), 0);
        check("overrun_sticky", overrun, 1'b1);

        // Reset after three words of a drain.
        pulse_start();
        feed_frame(8, 1'b0);
        for (int i = 0; i < 40 && exp_idx.size() != 5; i++) tick();
        check("mid_drain_reach", exp_idx.size(), 5);
        rst = 1'b1;
        exp_idx.delete();
        exp_data.delete();
        tick();
        check("mrst_rd_valid", rd_valid, 1'b0);
        check("mrst_rd_data", rd_data, 32'h0);
        check("mrst_rd_idx", rd_idx, 3'd0);
        check("mrst_rd_last", rd_last, 1'b0);
        check("mrst_frame_cnt", frame_cnt, 16'd0);
        check("mrst_overrun", overrun, 1'b0);
        check("mrst_short", short_frame, 1'b0);
        check("mrst_fft_start", fft_start, 1'b0);
        rst = 1'b0;
        tick();

        // Continuous mode: one request, three back-to-back frames.
        cont_mode = 1'b1;
        pulse_start();
        check("cont_first_start", fft_start, 1'b1);
        for (int f = 0; f < 3; f++) begin
            if (f > 0) wait_start();
            feed_frame(8, 1'b0);
            if (f == 2) cont_mode = 1'b0;
        end
        wait_frames(3, "cont_frame_cnt");
        check("exp_drained_cont", exp_idx.size(), 0);
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            if (fft_start) starts++;
            tick();
        end
        check("cont_stopped", starts, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
